vector_mul_add_unit: RTL and testbench

// - Multi-cycle vector multiply-and-add (MULANDADD) execution stage; feeds the register file's
//   128-bit MULANDADD temporary register via M_ALU_Out / MANDA_En.
// - Consumes 64-bit operands R, S from the register file read ports, plus 128-bit accumulator R2.
// - Processes one lane per cycle and writes all lanes as a single one-cycle write strobe.

---
 rtl/vector_mul_add_unit.sv | 118 +++++++++++
 tb/tb_vector_mul_add_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mul_add_unit.sv
// vector_mul_add_unit: multi-cycle lane-serial signed multiply-add.
// One lane per cycle; full 128-bit result published with a one-cycle strobe.
module vector_mul_add_unit #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    acc_en,
  input  logic [LANES*LANE_W-1:0] R,
  input  logic [LANES*LANE_W-1:0] S,
  input  logic [2*LANES*LANE_W-1:0] R2,
  output logic [2*LANES*LANE_W-1:0] M_ALU_Out,
  output logic                    MANDA_En,
  output logic                    busy
);

  localparam int OW = LANES * LANE_W;
  localparam int RW = 2 * OW;
  localparam int PW = 2 * LANE_W;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] a_q, a_d;
  logic [OW-1:0] b_q, b_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] res_q, res_d;
  logic [RW-1:0] out_q, out_d;
  logic          en_q, en_d;

  logic [LANE_W-1:0] a_lane, b_lane;
  logic [PW-1:0]     a_ext, b_ext;
  logic [PW-1:0]     acc_lane, lane_val;

  // Current lane operands, sign-extended so the product is exact.
  always_comb begin
    a_lane   = a_q[cnt_q*LANE_W +: LANE_W];
    b_lane   = b_q[cnt_q*LANE_W +: LANE_W];
    acc_lane = acc_q[cnt_q*PW +: PW];
    a_ext    = {{LANE_W{a_lane[LANE_W-1]}}, a_lane};
    b_ext    = {{LANE_W{b_lane[LANE_W-1]}}, b_lane};
    lane_val = (a_ext * b_ext) + acc_lane;
  end

  // Next-state logic: snapshot, lane sweep, then publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    out_d   = out_q;
    en_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = R;
          b_d     = S;
          acc_d   = acc_en ? R2 : '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[cnt_q*PW +: PW] = lane_val;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_d   = res_q;
        en_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      out_q   <= out_d;
      en_q    <= en_d;
    end
  end

  assign M_ALU_Out = out_q;
  assign MANDA_En  = en_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vector_mul_add_unit.sv
// tb_vector_mul_add_unit: randomized self-checking bench
// against a lane-wise arithmetic reference model.
module tb_vector_mul_add_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         acc_en = 1'b0;
  logic [63:0]  R = '0;
  logic [63:0]  S = '0;
  logic [127:0] R2 = '0;
  logic [127:0] M_ALU_Out;
  logic         MANDA_En;
  logic         busy;

  int n_run = 0;
  int n_fail = 0;

  vector_mul_add_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .acc_en(acc_en), .R(R), .S(S), .R2(R2),
    .M_ALU_Out(M_ALU_Out), .MANDA_En(MANDA_En),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model(
    input logic [63:0] r, input logic [63:0] s,
    input logic [127:0] r2, input logic a);
    logic [127:0] res;
    logic signed [15:0] x, y;
    logic signed [31:0] p, c;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      x = r[i*16 +: 16];
      y = s[i*16 +: 16];
      p = 32'(x) * 32'(y);
      c = a ? r2[i*32 +: 32] : 32'sd0;
      res[i*32 +: 32] = p + c;
    end
    return res;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(
    input logic [63:0] r, input logic [63:0] s,
    input logic [127:0] r2, input logic a,
    output logic [127:0] got, output int lat);
    @(negedge clk);
    R = r; S = s; R2 = r2; acc_en = a; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    R = r64(); S = r64(); R2 = r128();
    acc_en = ~a;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (MANDA_En) begin
        lat = k;
        got = M_ALU_Out;
        break;
      end
    end
  endtask

  task automatic check_op(
    input string nm, input logic [63:0] r,
    input logic [63:0] s, input logic [127:0] r2,
    input logic a);
    logic [127:0] got, exp;
    int lat;
    exp = model(r, s, r2, a);
    run_op(r, s, r2, a, got, lat);
    n_run++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 5", nm, lat);
    end
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_run++;
    if ({M_ALU_Out, MANDA_En, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset: out=%h en=%b busy=%b want 0",
               M_ALU_Out, MANDA_En, busy);
    end
  endtask

  task automatic test_basic();
    logic [127:0] got;
    int lat;
    check_op("basic", 64'h0004_0003_0002_0001,
             64'h0005_0005_0005_0005, 128'h0, 1'b0);
    n_run++;
    if (M_ALU_Out !==
        128'h00000014_0000000F_0000000A_00000005) begin
      n_fail++;
      $display("FAIL basic_const: got %h", M_ALU_Out);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (MANDA_En !== 1'b0 || M_ALU_Out !==
        128'h00000014_0000000F_0000000A_00000005) begin
      n_fail++;
      $display("FAIL basic_hold: en=%b out=%h want 0/held",
               MANDA_En, M_ALU_Out);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_run++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b want 1", busy);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    got = '0;
    lat = 0;
  endtask

  task automatic test_signed();
    check_op("signed", 64'h0000_0000_0000_FFFF,
             64'h0000_0000_0000_0002, 128'h0, 1'b0);
    n_run++;
    if (M_ALU_Out[31:0] !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL signed_const: got %h want fffffffe",
               M_ALU_Out[31:0]);
    end
  endtask

  task automatic test_acc_wrap();
    check_op("acc_wrap", 64'h1, 64'h1,
             {64'h0, 32'h12345678, 32'h7FFFFFFF}, 1'b1);
    n_run++;
    if (M_ALU_Out[63:0] !== 64'h12345678_80000000) begin
      n_fail++;
      $display("FAIL acc_wrap_const: got %h want %h",
               M_ALU_Out[63:0], 64'h12345678_80000000);
    end
  endtask

  task automatic test_extreme();
    check_op("extreme", {4{16'h8000}}, {4{16'h8000}},
             128'h0, 1'b0);
    n_run++;
    if (M_ALU_Out !== {4{32'h40000000}}) begin
      n_fail++;
      $display("FAIL extreme_const: got %h", M_ALU_Out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      check_op("random", r64(), r64(), r128(),
               1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  rq [$];
    logic [63:0]  sq [$];
    logic [127:0] r2q [$];
    logic         aq [$];
    logic [127:0] exp;
    int free_at, due;
    free_at = 0;
    due = -1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      R = r64(); S = r64(); R2 = r128();
      acc_en = 1'($urandom);
      start = (c < 14);
      if (start && c >= free_at) begin
        rq.push_back(R); sq.push_back(S);
        r2q.push_back(R2); aq.push_back(acc_en);
        free_at = c + 6;
        due = c + 5;
      end
      @(posedge clk);
      #1;
      n_run++;
      if (MANDA_En !== (c == due)) begin
        n_fail++;
        $display("FAIL b2b_strobe c=%0d: got %b want %b",
                 c, MANDA_En, c == due);
      end
      if (c == due && rq.size() > 0) begin
        exp = model(rq.pop_front(), sq.pop_front(),
                    r2q.pop_front(), aq.pop_front());
        n_run++;
        if (M_ALU_Out !== exp) begin
          n_fail++;
          $display("FAIL b2b_result c=%0d: got %h want %h",
                   c, M_ALU_Out, exp);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit seen;
    @(negedge clk);
    R = r64(); S = r64(); R2 = r128(); acc_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_run++;
    if (busy !== 1'b0 || M_ALU_Out !== '0 ||
        MANDA_En !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: busy=%b out=%h en=%b",
               busy, M_ALU_Out, MANDA_En);
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (MANDA_En) seen = 1'b1;
    end
    n_run++;
    if (seen) begin
      n_fail++;
      $display("FAIL midop_no_strobe: got strobe want none");
    end
    check_op("after_reset", r64(), r64(), r128(), 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_acc_wrap();
    test_extreme();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
